reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data width of each register.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers.
REQ-003 SHALL have parameter ZERO_REG, default 31, index of the hard-wired zero register (XZR).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_en  input  1  write enable.
REQ-007 SHALL have port wr_addr  input  $clog2(NREGS)  write register index.
REQ-008 SHALL have port wr_data  input  WIDTH  write data.
REQ-009 SHALL have port rd_addr_a  input  $clog2(NREGS)  read port A index.
REQ-010 SHALL have port rd_addr_b  input  $clog2(NREGS)  read port B index.
REQ-011 SHALL have port rd_data_a  output  WIDTH  read port A data.
REQ-012 SHALL have port rd_data_b  output  WIDTH  read port B data.

Function
REQ-013 SHALL store NREGS-1 WIDTH-bit registers; no storage SHALL exist for ZERO_REG.
REQ-014 SHALL write wr_data into register wr_addr on posedge clk when wr_en=1, reset_n=1 and wr_addr!=ZERO_REG.
REQ-015 SHALL ignore writes with wr_en=0 or wr_addr=ZERO_REG; all stored values hold.
REQ-016 SHALL drive rd_data_a/rd_data_b combinationally from the addressed register (zero-latency read).
REQ-017 SHALL drive 0 on any read port addressing ZERO_REG, regardless of any write in progress.
REQ-018 SHALL allow both read ports to address the same register simultaneously, returning identical data.
REQ-019 SHALL treat wr_addr >= NREGS and rd_addr >= NREGS (non-power-of-two NREGS) as no-write and read-0 respectively.
REQ-020 SHALL make a write visible on read ports no later than the cycle after its posedge (1-cycle write-to-read latency without bypass).

Reset
REQ-021 SHALL clear every stored register to 0 asynchronously when reset_n=0.
REQ-022 SHALL output 0 on both read ports for all addresses while reset_n=0.
REQ-023 SHALL ignore wr_en while reset_n=0; a write coincident with reset deassertion edge SHALL NOT be lost if reset_n is already 1 at that posedge.

Configuration
REQ-024 SHALL recognise macro REG_FILE_BYPASS_EN.
REQ-025 With REG_FILE_BYPASS_EN defined: when wr_en=1, wr_addr!=ZERO_REG and rd_addr_x==wr_addr in the same cycle, rd_data_x SHALL equal wr_data combinationally (write-through, 0-cycle).
REQ-026 Without REG_FILE_BYPASS_EN: that read SHALL return the old stored value until the posedge commits the write.
REQ-027 Bypass SHALL never apply to ZERO_REG nor while reset_n=0.

Structure
REQ-028 SHALL take ZERO_REG default, NREGS default and typedef reg_addr_t (5-bit) from shared package cpu_pkg.
REQ-029 SHALL build each storage element from the existing enabled flop sub-module register (WIDTH), enable = decoded wr_en & address match.
REQ-030 SHALL implement write-address decode and the two read multiplexers in reg_file itself; no other sub-modules.

Verification
REQ-031 Reset: reset_n=0 with prior contents -> all reads 0 immediately; after release, read X0..X30 -> 0.
REQ-032 Write/read: wr_en=1, wr_addr=5, wr_data=500 at edge N; rd_addr_a=5 -> 500 from cycle N+1; wr_en=0, wr_data=250 -> stays 500.
REQ-033 Zero reg: write 0xDEAD to 31 -> rd_data_a/b at 31 read 0; X0..X30 unchanged.
REQ-034 Dual read: X3=7, X4=9; rd_addr_a=3, rd_addr_b=4 -> 7/9; both at 4 -> 9/9.
REQ-035 Same-cycle write+read of X7 (old 1, new 2): with REG_FILE_BYPASS_EN -> 2 in write cycle; without -> 1, then 2 next cycle.
REQ-036 Mid-operation reset: reset_n pulsed low between edges after writing X10=0xFFFF_FFFF_FFFF_FFFF -> X10 reads 0 at once and after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants and types for the integer register file.
package cpu_pkg;
  localparam int NUM_REGS = 32;
  localparam int XZR = 31;
  typedef logic [4:0] reg_addr_t;
endpackage

// File: rtl/register.sv
// register: WIDTH-bit enabled flop with asynchronous active-low clear.
module register #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_q <= '0;
    else if (en_i) q_q <= d_i;
  end
  assign q_o = q_q;
endmodule

// File: rtl/reg_file.sv
// reg_file: 2-read/1-write register file with hard-wired zero register.
// Define REG_FILE_BYPASS_EN for same-cycle write-through on the read ports.
module reg_file
  import cpu_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int NREGS    = NUM_REGS,
  parameter int ZERO_REG = XZR
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(NREGS)-1:0] rd_addr_a,
  input  logic [$clog2(NREGS)-1:0] rd_addr_b,
  output logic [WIDTH-1:0]         rd_data_a,
  output logic [WIDTH-1:0]         rd_data_b
);
  localparam int AW = $clog2(NREGS);
  localparam int NSLOT = 2 ** AW;
  // Every encodable index gets a slot; the zero register and out-of-range indices have no flop.
  logic [WIDTH-1:0] slot [NSLOT];
  logic [NSLOT-1:0] live;
  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < NREGS && i != ZERO_REG) begin : g_reg
      assign live[i] = 1'b1;
      register #(.WIDTH(WIDTH)) u_reg (
        .clk    (clk),
        .reset_n(reset_n),
        .en_i   (wr_en && wr_addr == AW'(i)),
        .d_i    (wr_data),
        .q_o    (slot[i])
      );
    end else begin : g_zero
      assign live[i] = 1'b0;
      assign slot[i] = '0;
    end
  end
  logic byp_a, byp_b;
`ifdef REG_FILE_BYPASS_EN
  assign byp_a = wr_en && live[wr_addr] && wr_addr == rd_addr_a;
  assign byp_b = wr_en && live[wr_addr] && wr_addr == rd_addr_b;
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif
  always_comb begin
    rd_data_a = (!reset_n || !live[rd_addr_a]) ? '0 : byp_a ? wr_data : slot[rd_addr_a];
    rd_data_b = (!reset_n || !live[rd_addr_b]) ? '0 : byp_b ? wr_data : slot[rd_addr_b];
  end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: table-driven scoreboard bench for reg_file.
module tb_reg_file;
  import cpu_pkg::*;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  typedef struct {
    logic we;
    reg_addr_t wa;
    logic [63:0] wd;
    reg_addr_t ra, rb;
    logic [63:0] ea, eb;
  } vec_t;
  typedef struct {
    string name;
    logic [63:0] a, b;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n;
  logic wr_en;
  reg_addr_t wr_addr, rd_addr_a, rd_addr_b;
  logic [63:0] wr_data, rd_data_a, rd_data_b;
  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];
  vec_t tbl[14];
  logic [63:0] mem_exp [32];
  reg_file dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  // Drive one cycle's inputs after the falling edge, then check the combinational reads.
  task automatic drive(input logic we, input reg_addr_t wa, input logic [63:0] wd,
                       input reg_addr_t ra, input reg_addr_t rb,
                       input logic [63:0] ea, input logic [63:0] eb, input string name);
    exp_t e;
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
    sb.push_back('{name, ea, eb});
    #1;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      chk({e.name, ".a"}, rd_data_a, e.a);
      chk({e.name, ".b"}, rd_data_b, e.b);
    end
  endtask
  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    drive(1'b1, 5'd10, 64'd5, 5'd10, 5'd31, 64'd0, 64'd0, "in_reset");
    drive(1'b1, 5'd10, 64'd5, 5'd10, 5'd3, 64'd0, 64'd0, "in_reset_edge");
    wr_en = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 31; i++)
      drive(1'b0, 5'd0, 64'd0, 5'(i), 5'(30 - i), 64'd0, 64'd0, $sformatf("post_reset_x%0d", i));
    tbl[0]  = '{1'b1, 5'd5,  64'd500,    5'd5,  5'd0,  BYP ? 64'd500 : 64'd0, 64'd0};
    tbl[1]  = '{1'b0, 5'd5,  64'd250,    5'd5,  5'd5,  64'd500, 64'd500};
    tbl[2]  = '{1'b1, 5'd31, 64'hDEAD,   5'd31, 5'd31, 64'd0, 64'd0};
    tbl[3]  = '{1'b0, 5'd0,  64'd0,      5'd31, 5'd5,  64'd0, 64'd500};
    tbl[4]  = '{1'b1, 5'd3,  64'd7,      5'd3,  5'd4,  BYP ? 64'd7 : 64'd0, 64'd0};
    tbl[5]  = '{1'b1, 5'd4,  64'd9,      5'd3,  5'd4,  64'd7, BYP ? 64'd9 : 64'd0};
    tbl[6]  = '{1'b0, 5'd0,  64'd0,      5'd3,  5'd4,  64'd7, 64'd9};
    tbl[7]  = '{1'b0, 5'd0,  64'd0,      5'd4,  5'd4,  64'd9, 64'd9};
    tbl[8]  = '{1'b1, 5'd7,  64'd1,      5'd0,  5'd30, 64'd0, 64'd0};
    tbl[9]  = '{1'b1, 5'd7,  64'd2,      5'd7,  5'd7,  BYP ? 64'd2 : 64'd1, BYP ? 64'd2 : 64'd1};
    tbl[10] = '{1'b0, 5'd7,  64'd3,      5'd7,  5'd7,  64'd2, 64'd2};
    tbl[11] = '{1'b1, 5'd0,  64'h1234,   5'd0,  5'd30, BYP ? 64'h1234 : 64'd0, 64'd0};
    tbl[12] = '{1'b1, 5'd30, ONES,       5'd0,  5'd30, 64'h1234, BYP ? ONES : 64'd0};
    tbl[13] = '{1'b0, 5'd30, 64'd0,      5'd0,  5'd30, 64'h1234, ONES};
    foreach (tbl[i])
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb, tbl[i].ea, tbl[i].eb,
            $sformatf("vec%0d", i));
    foreach (mem_exp[i]) mem_exp[i] = 64'd0;
    mem_exp[0] = 64'h1234; mem_exp[3] = 64'd7; mem_exp[4] = 64'd9;
    mem_exp[5] = 64'd500; mem_exp[7] = 64'd2; mem_exp[30] = ONES;
    for (int i = 0; i < 32; i++)
      drive(1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i), mem_exp[i], mem_exp[31 - i],
            $sformatf("readback_x%0d", i));
    drive(1'b1, 5'd10, ONES, 5'd10, 5'd5, BYP ? ONES : 64'd0, 64'd500, "x10_write");
    drive(1'b0, 5'd10, 64'd0, 5'd10, 5'd5, ONES, 64'd500, "x10_read");
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_x10", rd_data_a, 64'd0);
    chk("midreset_x5", rd_data_b, 64'd0);
    drive(1'b1, 5'd10, 64'h55, 5'd10, 5'd5, 64'd0, 64'd0, "reset_wr_ignored");
    drive(1'b1, 5'd12, 64'h77, 5'd12, 5'd10, 64'd0, 64'd0, "reset_release_wr");
    reset_n = 1'b1;
    drive(1'b0, 5'd0, 64'd0, 5'd12, 5'd10, 64'h77, 64'd0, "wr_at_release");
    for (int i = 0; i < 31; i++)
      drive(1'b0, 5'd0, 64'd0, 5'(i), 5'(30 - i), (i == 12) ? 64'h77 : 64'd0,
            (30 - i == 12) ? 64'h77 : 64'd0, $sformatf("after_midreset_x%0d", i));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
